fetch_decode: RTL
=================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst; both SHALL be sampled on the rising edge of clk only.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 run  input  1  enables fetching; level-sensitive.
REQ-005 pc_load  input  1  loads a new program counter value; honoured only in IDLE.
REQ-006 pc_load_val  input  4  value loaded into pc.
REQ-007 rom_addr  output  4  address to the 16x11 synchronous instruction ROM; equals pc at all times.
REQ-008 rom_data  input  11  ROM word {funct[10:6], src[5:3], dst[2:0]}; valid one edge after rom_addr is sampled.
REQ-009 instr_valid  output  1  decoded instruction available.
REQ-010 instr_ready  input  1  downstream accepts the instruction.
REQ-011 op_funct  output  5  rom_data[10:6] as captured.
REQ-012 op_src  output  3  rom_data[5:3] as captured.
REQ-013 op_dst  output  3  rom_data[2:0] as captured.
REQ-014 op_is_move  output  1  1 when captured funct equals 11010.
REQ-015 op_alu_sel  output  4  captured funct[4:1]; 0 when op_is_move=1.
REQ-016 op_illegal  output  1  captured funct is not in the legal set (REQ-022).
REQ-017 pc  output  4  current program counter.
REQ-018 wrapped  output  1  one-cycle pulse when pc advances from 15 to 0.
REQ-019 halted  output  1  block is in HALT.

Function
REQ-020 The states SHALL be IDLE, ADDR, CAPT, ISSUE and HALT.
- IDLE: pc_load=1 sets pc to pc_load_val and the state stays IDLE. Otherwise run=1 goes to ADDR. pc_load takes priority over run in the same cycle.
- ADDR: rom_addr=pc is held for one edge so the ROM can register it; the next state is always CAPT.
- CAPT: at the edge, rom_data is captured into the op_* registers and instr_valid is set to 1; the next state is ISSUE.
- ISSUE: the op_* registers and instr_valid are held stable until the edge where instr_valid=1 and instr_ready=1.
- ISSUE handshake edge: instr_valid goes to 0. If op_illegal=1, the next state is HALT and pc does not change. Otherwise pc increments modulo 16, and the next state is ADDR if run=1, else IDLE.
- HALT: instr_valid=0 and halted=1; pc_load and run are ignored; only rst exits HALT.
REQ-021 Latency SHALL be: entry to ADDR to instr_valid=1 takes exactly 2 edges, and sustained throughput SHALL be one instruction per 3 cycles when instr_ready is held at 1.
REQ-022 The legal funct set SHALL be 00001, 00011, 00101, 00111, 01001, 01011, 10001, 10011, 10101, 10111, 11001 and 11010; every other code SHALL set op_illegal=1.
REQ-023 op_is_move, op_alu_sel and op_illegal SHALL be registered at the CAPT edge together with op_funct, op_src and op_dst.
REQ-024 If run is deasserted during ADDR, CAPT or ISSUE, the in-flight fetch SHALL complete and be issued, then the block SHALL go to IDLE.
REQ-025 pc_load in any state other than IDLE SHALL be ignored.
REQ-026 wrapped SHALL be 1 for exactly the cycle following a handshake that moves pc from 15 to 0, and 0 otherwise.
REQ-027 instr_ready while instr_valid=0 SHALL have no effect.

Reset
REQ-028 When rst=1 at an edge, and in every state including mid-handshake, the block SHALL set: state=IDLE, pc=0, instr_valid=0, op_funct=0, op_src=0, op_dst=0, op_is_move=0, op_alu_sel=0, op_illegal=0, wrapped=0 and halted=0.
REQ-029 rst SHALL take priority over pc_load, run and instr_ready in the same cycle.

Verification
REQ-030 Basic fetch: ROM[0]=11010_011_001, rst then run=1, instr_ready=1.
-> instr_valid=1 on the 2nd edge after ADDR is entered, with op_is_move=1, op_src=3, op_dst=1, op_alu_sel=0, and pc=1 after the handshake.
REQ-031 Backpressure: instr_ready=0 for 5 cycles in ISSUE.
-> Outputs are stable and pc is unchanged; when instr_ready=1, exactly one handshake occurs.
REQ-032 Wrap: pc_load_val=15 in IDLE, then run, with ROM[15]=10111_000_100.
-> op_alu_sel=1011, and after the handshake pc=0 with wrapped=1 for one cycle.
REQ-033 Illegal opcode: ROM[2]=00000_000_000 reached.
-> op_illegal=1; after the handshake, halted=1 and pc=2, and run/pc_load are ignored until rst.
REQ-034 Run drop: run goes to 0 in CAPT.
-> The instruction is still issued, then the state is IDLE and there is no further ADDR.
REQ-035 Reset mid-op: rst=1 in ISSUE with instr_valid=1 and pc=7.
-> On the next cycle instr_valid=0, pc=0 and the state is IDLE.

Source files
------------

// File: rtl/fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode
// Brief    : Fetches 11-bit words from a 16-entry synchronous ROM, decodes them
//            and issues them through a valid/ready handshake; halts on illegal.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_decode (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        pc_load,
   input  logic [3:0]  pc_load_val,
   output logic [3:0]  rom_addr,
   input  logic [10:0] rom_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [4:0]  op_funct,
   output logic [2:0]  op_src,
   output logic [2:0]  op_dst,
   output logic        op_is_move,
   output logic [3:0]  op_alu_sel,
   output logic        op_illegal,
   output logic [3:0]  pc,
   output logic        wrapped,
   output logic        halted
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_CAPT  = 3'd2;
   localparam logic [2:0] S_ISSUE = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   localparam logic [4:0] C_FUNCT_MOVE = 5'b11010;

   logic [2:0] r_state;
   logic [2:0] w_state_nxt;
   logic [3:0] r_pc;
   logic       r_valid;
   logic [4:0] r_funct;
   logic [2:0] r_src;
   logic [2:0] r_dst;
   logic       r_is_move;
   logic [3:0] r_alu_sel;
   logic       r_illegal;
   logic       r_wrapped;

   logic       w_load;
   logic       w_capture;
   logic       w_fire;
   logic       w_legal;
   logic       w_is_move;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // pc_load wins over run in IDLE; HALT is only left through rst
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (!pc_load && run) w_state_nxt = S_ADDR;
         S_ADDR:  w_state_nxt = S_CAPT;
         S_CAPT:  w_state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (w_fire) begin
               if (r_illegal) begin
                  w_state_nxt = S_HALT;
               end else if (run) begin
                  w_state_nxt = S_ADDR;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_load    = (r_state == S_IDLE) && pc_load;
      w_capture = (r_state == S_CAPT);
      w_fire    = (r_state == S_ISSUE) && r_valid && instr_ready;
      halted    = (r_state == S_HALT);
   end

   always_comb begin
      w_is_move = (rom_data[10:6] == C_FUNCT_MOVE);
      case (rom_data[10:6])
         5'b00001, 5'b00011, 5'b00101, 5'b00111,
         5'b01001, 5'b01011, 5'b10001, 5'b10011,
         5'b10101, 5'b10111, 5'b11001, 5'b11010: w_legal = 1'b1;
         default:                                w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc      <= 4'd0;
         r_valid   <= 1'b0;
         r_funct   <= 5'd0;
         r_src     <= 3'd0;
         r_dst     <= 3'd0;
         r_is_move <= 1'b0;
         r_alu_sel <= 4'd0;
         r_illegal <= 1'b0;
         r_wrapped <= 1'b0;
      end else begin
         r_wrapped <= 1'b0;
         if (w_load) begin
            r_pc <= pc_load_val;
         end
         if (w_capture) begin
            r_valid   <= 1'b1;
            r_funct   <= rom_data[10:6];
            r_src     <= rom_data[5:3];
            r_dst     <= rom_data[2:0];
            r_is_move <= w_is_move;
            r_alu_sel <= w_is_move ? 4'd0 : rom_data[10:7];
            r_illegal <= !w_legal;
         end
         // an illegal word freezes pc so it still points at the offender
         if (w_fire) begin
            r_valid <= 1'b0;
            if (!r_illegal) begin
               r_pc      <= r_pc + 4'd1;
               r_wrapped <= (r_pc == 4'd15);
            end
         end
      end
   end

   assign rom_addr    = r_pc;
   assign pc          = r_pc;
   assign instr_valid = r_valid;
   assign op_funct    = r_funct;
   assign op_src      = r_src;
   assign op_dst      = r_dst;
   assign op_is_move  = r_is_move;
   assign op_alu_sel  = r_alu_sel;
   assign op_illegal  = r_illegal;
   assign wrapped     = r_wrapped;

endmodule
`default_nettype wire
